// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership states and the
// MMIO print address that riscv_dmem decodes.
package riscv_dmem_arbiter_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } arb_state_t;

   localparam logic [31:0] MMIO_PRINT_ADDR = 32'h8000_0000;

endpackage

// File: rtl/riscv_dmem_arbiter.sv
// Single-port data memory arbiter: CPU has default priority, DMA gets idle
// cycles or is forced in on starvation, then owns the memory for a bounded burst.
module riscv_dmem_arbiter
   import riscv_dmem_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_BURST    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   input  logic          dma_last,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t    r_state;
   arb_state_t    w_state_next;
   logic [BW-1:0] r_beat_cnt;
   logic [SW-1:0] r_starve_cnt;
   logic [BW-1:0] w_beat_inc;
   logic          w_starved;
   logic          w_cpu_gnt;
   logic          w_dma_gnt;

   assign w_beat_inc = r_beat_cnt + BW'(1);
   assign w_starved  = (r_starve_cnt == STARVE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CPU;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A burst of one beat never enters S_DMA, whether by dma_last or by the cap.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_CPU: begin
            if (w_dma_gnt && !dma_last && (MAX_BURST > 1))
               w_state_next = S_DMA;
         end
         S_DMA: begin
            if (!dma_req || dma_last || (w_beat_inc >= BURST_MAX))
               w_state_next = S_CPU;
         end
         default: w_state_next = S_CPU;
      endcase
   end

   always_comb begin
      w_dma_gnt = 1'b0;
      w_cpu_gnt = 1'b0;
      unique case (r_state)
         S_CPU: begin
            w_dma_gnt = dma_req & (~cpu_req | w_starved);
            w_cpu_gnt = cpu_req & ~w_dma_gnt;
         end
         S_DMA: w_dma_gnt = dma_req;
         default: ;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else if (w_cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_gnt = w_cpu_gnt;
   assign dma_gnt = w_dma_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt   <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (w_dma_gnt)
            r_beat_cnt <= (r_state == S_CPU) ? BW'(1) : w_beat_inc;
         if (dma_req && !w_dma_gnt) begin
            if (!w_starved)
               r_starve_cnt <= r_starve_cnt + SW'(1);
         end else begin
            r_starve_cnt <= '0;
         end
      end
   end

   // Only the winner of a read captures mem_rdata; the other port's data holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         cpu_rvalid <= w_cpu_gnt & ~cpu_we;
         dma_rvalid <= w_dma_gnt & ~dma_we;
         if (w_cpu_gnt && !cpu_we)
            cpu_rdata <= mem_rdata;
         if (w_dma_gnt && !dma_we)
            dma_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter with a small behavioural data memory:
// a vector table for single-cycle arbitration, then multi-cycle burst/reset sequences.
module tb_riscv_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem_model [0:255];

   always #5 clk = ~clk;

   riscv_dmem_arbiter #(
      .AW(32), .DW(32), .MAX_BURST(8), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Stand-in for riscv_dmem: combinational read, write at posedge.
   assign mem_rdata = mem_model[mem_addr[9:2]];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
      end else if (mem_we) begin
         mem_model[mem_addr[9:2]] <= mem_wdata;
      end
   end

   typedef struct {
      logic        cpu_req, cpu_we;
      logic [31:0] cpu_addr, cpu_wdata;
      logic        dma_req, dma_we;
      logic [31:0] dma_addr, dma_wdata;
      logic        dma_last;
      logic        e_cpu_gnt, e_dma_gnt, e_mem_we;
      logic [31:0] e_mem_addr, e_mem_wdata;
      logic        e_cpu_rv, e_dma_rv;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [0:NV-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic dl);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_last = dl;
   endtask

   // Called at posedge+1 with inputs applied; checks grants at the negedge.
   task automatic gnt_cycle(input string tag, input logic ecg, input logic edg);
      #4;
      $display("%s cpu_gnt=%b dma_gnt=%b mem_we=%b mem_addr=%h", tag, cpu_gnt, dma_gnt, mem_we, mem_addr);
      chk({tag, "_cpu_gnt"}, {31'h0, cpu_gnt}, {31'h0, ecg});
      chk({tag, "_dma_gnt"}, {31'h0, dma_gnt}, {31'h0, edg});
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0,
                  1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0};
      vecs[1] = '{1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,1'b0,
                  1'b1,1'b0,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0};
      vecs[2] = '{1'b1,1'b0,32'h10,32'h1234, 1'b0,1'b0,32'h0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,32'h10,32'h1234, 1'b1,1'b0,32'hDEADBEEF};
      vecs[3] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h20,32'hA5A5A5A5,1'b1,
                  1'b0,1'b1,1'b1,32'h20,32'hA5A5A5A5, 1'b0,1'b0,32'h0};
      vecs[4] = '{1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h10,32'h0,1'b1,
                  1'b1,1'b0,1'b0,32'h20,32'h0, 1'b1,1'b0,32'hA5A5A5A5};
      vecs[5] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0,1'b1,
                  1'b0,1'b1,1'b0,32'h10,32'h0, 1'b0,1'b1,32'hDEADBEEF};
      vecs[6] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h80000000,32'h41,1'b1,
                  1'b0,1'b1,1'b1,32'h80000000,32'h41, 1'b0,1'b0,32'h0};
      vecs[7] = '{1'b1,1'b1,32'h80000000,32'h42, 1'b0,1'b0,32'h0,32'h0,1'b0,
                  1'b1,1'b0,1'b1,32'h80000000,32'h42, 1'b0,1'b0,32'h0};
      vecs[8] = '{1'b1,1'b0,32'h20,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0,
                  1'b1,1'b0,1'b0,32'h20,32'h0, 1'b1,1'b0,32'hA5A5A5A5};

      set_in(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
      chk("reset_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
      chk("reset_cpu_rdata", cpu_rdata, 32'h0);
      chk("reset_dma_rdata", dma_rdata, 32'h0);
      rst_n = 1'b1;

      // Single-cycle vectors from S_CPU.
      for (int i = 0; i < NV; i++) begin
         set_in(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
                vecs[i].dma_req, vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_wdata, vecs[i].dma_last);
         #4;
         $display("vec %0d cpu_gnt=%b dma_gnt=%b mem_we=%b mem_addr=%h mem_wdata=%h",
                  i, cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata);
         chk($sformatf("vec%0d_cpu_gnt", i), {31'h0, cpu_gnt}, {31'h0, vecs[i].e_cpu_gnt});
         chk($sformatf("vec%0d_dma_gnt", i), {31'h0, dma_gnt}, {31'h0, vecs[i].e_dma_gnt});
         chk($sformatf("vec%0d_mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_mem_we});
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
         chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_cpu_rvalid", i), {31'h0, cpu_rvalid}, {31'h0, vecs[i].e_cpu_rv});
         chk($sformatf("vec%0d_dma_rvalid", i), {31'h0, dma_rvalid}, {31'h0, vecs[i].e_dma_rv});
         if (vecs[i].e_cpu_rv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
         if (vecs[i].e_dma_rv) chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, vecs[i].e_rdata);
      end
      chk("dma_rdata_hold", dma_rdata, 32'hDEADBEEF);

      // Contention: CPU wins 4 cycles, DMA forced in on cycle 5, owns 8 beats.
      for (int c = 1; c <= 13; c++) begin
         set_in(1'b1,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0,1'b0);
         gnt_cycle($sformatf("contend_c%0d", c), !(c >= 5 && c <= 12), (c >= 5 && c <= 12));
         if (c == 5) begin
            chk("contend_dma_rvalid", {31'h0, dma_rvalid}, 32'h1);
            chk("contend_dma_rdata", dma_rdata, 32'hDEADBEEF);
            chk("contend_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
         end
      end
      set_in(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0);
      gnt_cycle("contend_idle", 1'b0, 1'b0);

      // Three-beat write burst ending on dma_last while the CPU waits.
      set_in(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h30,32'h1,1'b0);
      gnt_cycle("burst3_b1", 1'b0, 1'b1);
      set_in(1'b1,1'b0,32'h34,32'h0, 1'b1,1'b1,32'h34,32'h2,1'b0);
      gnt_cycle("burst3_b2", 1'b0, 1'b1);
      set_in(1'b1,1'b0,32'h34,32'h0, 1'b1,1'b1,32'h38,32'h3,1'b1);
      gnt_cycle("burst3_b3", 1'b0, 1'b1);
      set_in(1'b1,1'b0,32'h34,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0);
      gnt_cycle("burst3_cpu", 1'b1, 1'b0);
      chk("burst3_cpu_rdata", cpu_rdata, 32'h2);
      set_in(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0);
      gnt_cycle("burst3_idle", 1'b0, 1'b0);

      // Burst cap: ownership lapses after 8 beats; beat 9 re-enters via S_CPU.
      for (int b = 1; b <= 8; b++) begin
         set_in(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h40 + 32'(4*b),32'(b),1'b0);
         gnt_cycle($sformatf("cap_b%0d", b), 1'b0, 1'b1);
      end
      set_in(1'b1,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h64,32'h9,1'b0);
      gnt_cycle("cap_cpu_wins", 1'b1, 1'b0);
      set_in(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h64,32'h9,1'b0);
      gnt_cycle("cap_b9", 1'b0, 1'b1);
      for (int b = 10; b <= 12; b++) begin
         set_in(1'b1,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h40 + 32'(4*b),32'(b),(b == 12));
         gnt_cycle($sformatf("cap_b%0d", b), 1'b0, 1'b1);
      end
      set_in(1'b1,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0);
      gnt_cycle("cap_cpu_after", 1'b1, 1'b0);
      chk("cap_cpu_rdata", cpu_rdata, 32'h42);

      // Asynchronous reset in the middle of a DMA read burst (beat_cnt=3).
      for (int b = 1; b <= 3; b++) begin
         set_in(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0,1'b0);
         gnt_cycle($sformatf("rst_b%0d", b), 1'b0, 1'b1);
      end
      chk("rst_pre_dma_rvalid", {31'h0, dma_rvalid}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      $display("async reset dma_rvalid=%b dma_rdata=%h cpu_rdata=%h", dma_rvalid, dma_rdata, cpu_rdata);
      chk("rst_async_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
      chk("rst_async_dma_rdata", dma_rdata, 32'h0);
      chk("rst_async_cpu_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1;
      chk("rst_held_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
      chk("rst_held_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
      rst_n = 1'b1;
      set_in(1'b1,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0,1'b0);
      gnt_cycle("rst_release", 1'b1, 1'b0);
      chk("rst_release_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
